instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Upstream instruction source for the processor. Holds a small program memory and a program counter.
//  Drives the processor's 16-bit iin word, keeping each word stable for exactly one instruction slot
//  of SLOT_CYCLES clocks, which matches the processor's 2-bit step counter (00..11).
//  A serial load port fills the program while the block is stopped. run starts execution from address 0.
// PARAMETERS
//  WORD_W       16  instruction width; must equal processor iin width
//  ADDR_W        6  program-memory address width
//  DEPTH        64  program-memory words (2**ADDR_W)
//  SLOT_CYCLES   4  clocks per instruction slot (>=2)
// PORTS
//  clock       in   1       system clock; all state updates on posedge
//  reset       in   1       synchronous, active-high reset
//  load_en     in   1       write load_data to load_addr this cycle (IDLE/HALTED only)
//  load_addr   in   ADDR_W  load write address
//  load_data   in   WORD_W  load write data
//  run         in   1       start-execution request (level sampled each clock)
//  iin         out  WORD_W  instruction word to processor; registered
//  pc          out  ADDR_W  address of the word currently on iin
//  slot        out  2       position inside current slot (0..SLOT_CYCLES-1)
//  instr_start out  1       high on the first cycle of every slot (slot==0 while RUNNING)
//  busy        out  1       high in RUNNING
//  halted      out  1       high in HALTED
// BEHAVIOUR
//  Reset: state=IDLE, iin=0, pc=0, slot=0, prog_len=0, instr_start=0, busy=0, halted=0.
//  Reset does not clear memory contents. Reset mid-run aborts at once; the next clock shows reset values.
//  States: IDLE -> RUNNING -> HALTED -> (run) RUNNING.
//  Load: in IDLE or HALTED, load_en writes mem[load_addr] on posedge.
//   prog_len <= max(prog_len, load_addr+1), held in ADDR_W+1 bits.
//   load_en in RUNNING is ignored: no write, and prog_len is unchanged.
//  Start: run=1 in IDLE/HALTED with prog_len>0 -> next clock: RUNNING, pc=0, iin=mem[0], slot=0, instr_start=1.
//   load_en and run in the same cycle: the write completes first, so the updated prog_len/mem are used.
//   run=1 with prog_len==0 -> HALTED; iin unchanged.
//  RUNNING:
//   slot increments every clock.
//   At slot==SLOT_CYCLES-1:
//    if pc+1 < prog_len: pc<=pc+1, iin<=mem[pc+1], slot<=0.
//    else: -> HALTED; pc and iin hold their last values; slot<=0.
//   iin changes only on slot boundaries, so it is stable for SLOT_CYCLES clocks (processor latches fields at its step 00).
//   run is ignored while RUNNING.
//  HALTED: iin/pc held; halted=1; busy=0. run restarts from address 0.
//  Memory reads are combinational (mem[addr]); the value is captured into the iin register, so iin latency is 1 clock.
//  pc wrap-around is impossible: prog_len<=DEPTH bounds pc at DEPTH-1.
// STRUCTURE
//  Shared package proc_defs:
//   WORD_W
//   opcode constants LDI=3'b101, OUT=3'b100, REP=3'b111
//   state encoding IDLE=2'd0, RUNNING=2'd1, HALTED=2'd2
//  Sub-module instr_mem: DEPTH x WORD_W, one synchronous write port (we, waddr, wdata), one combinational read port.
//  FSM, pc, slot counter and prog_len stay in instr_fetch.
// TESTING
//  1 Reset with run=0 -> iin=0, pc=0, busy=0, halted=0; after reset release, run=1 with nothing loaded
//    -> halted=1 next clock.
//  2 Load 3 words (A000,1C80,9000) at 0..2, pulse run -> iin=A000 for 4 clocks, 1C80 for 4, 9000 for 4,
//    then halted=1 with iin=9000, pc=2; instr_start high at cycles 1,5,9.
//  3 During RUNNING drive load_en addr 1 data FFFF -> memory unchanged; second run after halt replays 1C80.
//  4 Assert reset at slot 2 of word 1 -> next clock iin=0, pc=0, busy=0, state IDLE; memory preserved
//    (run replays A000).
//  5 Load addr 63 only (prog_len=64), run -> pc reaches 63 with no wrap, then HALTED.
//  6 load_en addr 0 data 5555 with run in the same cycle from HALTED -> first issued iin=5555.

Source files
------------

// File: rtl/proc_defs.sv
// proc_defs: shared widths, opcode constants and fetch-state encoding
package proc_defs;
  localparam int WORD_W = 16;
  localparam logic [2:0] LDI = 3'b101;
  localparam logic [2:0] OUT = 3'b100;
  localparam logic [2:0] REP = 3'b111;
  typedef enum logic [1:0] {IDLE = 2'd0, RUNNING = 2'd1, HALTED = 2'd2} state_t;
endpackage

// File: rtl/instr_mem.sv
// instr_mem: program store with one synchronous write port and a combinational read port
module instr_mem import proc_defs::*; #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: serially loaded program store feeding one instruction word per SLOT_CYCLES-clock slot
module instr_fetch import proc_defs::*; #(
  parameter int ADDR_W      = 6,
  parameter int DEPTH       = 64,
  parameter int SLOT_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WORD_W-1:0] load_data,
  input  logic              run,
  output logic [WORD_W-1:0] iin,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        slot,
  output logic              instr_start,
  output logic              busy,
  output logic              halted
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, raddr;
  logic [1:0]        slot_q, slot_d;
  logic [ADDR_W:0]   len_q, len_d, len_w, addr_len, pc_inc;
  logic [WORD_W-1:0] iin_q, iin_d, rdata, word0;
  logic              start_q, start_d, stopped, we, last_slot;
  instr_mem #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem (
    .clock(clock), .we(we), .waddr(load_addr), .wdata(load_data), .raddr(raddr), .rdata(rdata)
  );
  always_comb begin
    stopped   = state_q != RUNNING;
    we        = load_en && stopped;
    addr_len  = {1'b0, load_addr} + (ADDR_W+1)'(1);
    len_w     = (we && addr_len > len_q) ? addr_len : len_q;
    last_slot = slot_q == 2'(SLOT_CYCLES - 1);
    pc_inc    = {1'b0, pc_q} + (ADDR_W+1)'(1);
    raddr     = stopped ? '0 : pc_q + ADDR_W'(1);
    // a same-cycle write to word 0 must win over the stale array contents
    word0     = (we && load_addr == '0) ? load_data : rdata;
    state_d   = state_q;
    pc_d      = pc_q;
    slot_d    = slot_q;
    len_d     = len_w;
    iin_d     = iin_q;
    start_d   = 1'b0;
    if (stopped && run) begin
      state_d = (len_w != '0) ? RUNNING : HALTED;
      if (len_w != '0) begin
        pc_d    = '0;
        slot_d  = '0;
        iin_d   = word0;
        start_d = 1'b1;
      end
    end else if (!stopped) begin
      slot_d = last_slot ? 2'd0 : slot_q + 2'd1;
      if (last_slot && pc_inc < len_q) begin
        pc_d    = pc_q + ADDR_W'(1);
        iin_d   = rdata;
        start_d = 1'b1;
      end else if (last_slot) begin
        state_d = HALTED;
      end
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      slot_q  <= '0;
      len_q   <= '0;
      iin_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      slot_q  <= slot_d;
      len_q   <= len_d;
      iin_q   <= iin_d;
      start_q <= start_d;
    end
  assign iin         = iin_q;
  assign pc          = pc_q;
  assign slot        = slot_q;
  assign instr_start = start_q;
  assign busy        = state_q == RUNNING;
  assign halted      = state_q == HALTED;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench; the model expands each run into the expected per-cycle slot stream
module tb_instr_fetch;
  typedef struct {
    logic [15:0] iin;
    logic [5:0]  pc;
    logic [1:0]  slot;
    logic        st;
  } exp_t;
  logic        clock = 0, reset = 1, load_en = 0, run = 0;
  logic [5:0]  load_addr = 0;
  logic [15:0] load_data = 0;
  logic [15:0] iin;
  logic [5:0]  pc;
  logic [1:0]  slot;
  logic        instr_start, busy, halted;
  exp_t        q[$];
  logic [15:0] mem_m [64];
  int          len_m = 0;
  int          n_chk = 0, n_fail = 0;
  instr_fetch dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .run(run), .iin(iin), .pc(pc), .slot(slot), .instr_start(instr_start), .busy(busy), .halted(halted)
  );
  always #5 clock = ~clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(negedge clock)
    if (busy) begin
      if (q.size() == 0) chk("unexpected_busy", 32'(busy), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("iin", 32'(iin), 32'(e.iin));
        chk("pc", 32'(pc), 32'(e.pc));
        chk("slot", 32'(slot), 32'(e.slot));
        chk("instr_start", 32'(instr_start), 32'(e.st));
      end
    end
  // drive one cycle of stimulus from a stopped state and update the model
  task automatic issue(input bit le, input logic [5:0] a, input logic [15:0] d, input bit r);
    load_en = le; load_addr = a; load_data = d; run = r;
    if (le) begin
      mem_m[a] = d;
      if (int'(a) + 1 > len_m) len_m = int'(a) + 1;
    end
    if (r)
      for (int w = 0; w < len_m; w++)
        for (int s = 0; s < 4; s++) q.push_back('{mem_m[w], 6'(w), 2'(s), s == 0});
    @(negedge clock);
    load_en = 0; run = 0;
  endtask
  task automatic wait_halt(input bit noise);
    int n = 0;
    while (!halted && n < 400) begin
      @(negedge clock);
      n++;
      if (!halted && noise) begin
        load_en = ($urandom_range(0, 3) == 0);
        load_addr = 6'($urandom_range(0, 63));
        load_data = 16'($urandom);
      end
    end
    load_en = 0;
    chk("halt_reached", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_iin", 32'(iin), 32'(mem_m[len_m-1]));
    chk("halt_pc", 32'(pc), 32'(len_m - 1));
    chk("halt_slot", 32'(slot), 32'd0);
    chk("halt_start", 32'(instr_start), 32'd0);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask
  task automatic check_reset_vals();
    chk("rst_iin", 32'(iin), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_start", 32'(instr_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
  endtask
  initial begin
    int n;
    repeat (2) @(negedge clock);
    check_reset_vals();
    reset = 0;
    issue(0, 0, 0, 1);
    chk("empty_run_halted", 32'(halted), 32'd1);
    chk("empty_run_iin", 32'(iin), 32'd0);
    issue(1, 0, 16'hA000, 0);
    issue(1, 1, 16'h1C80, 0);
    issue(1, 2, 16'h9000, 0);
    issue(0, 0, 0, 1);
    wait_halt(0);
    issue(0, 0, 0, 1);
    repeat (3) @(negedge clock);
    load_en = 1; load_addr = 1; load_data = 16'hFFFF;
    @(negedge clock);
    load_en = 0;
    wait_halt(0);
    issue(0, 0, 0, 1);
    wait_halt(0);
    issue(0, 0, 0, 1);
    n = 0;
    while (!(pc == 1 && slot == 2) && n < 50) begin @(negedge clock); n++; end
    chk("reached_word1_slot2", 32'(n < 50), 32'd1);
    reset = 1;
    @(negedge clock);
    check_reset_vals();
    reset = 0;
    q.delete();
    len_m = 0;
    issue(1, 1, 16'h1C80, 0);
    issue(0, 0, 0, 1);
    wait_halt(0);
    for (int it = 0; it < 12; it++) begin
      int k;
      bit joint;
      k = $urandom_range(1, 4);
      joint = $urandom_range(0, 1);
      for (int j = 0; j < k; j++)
        issue(1, 6'($urandom_range(0, 7)), 16'($urandom), joint && j == k - 1);
      if (!joint) issue(0, 0, 0, 1);
      wait_halt(1);
    end
    for (int a = 0; a < 64; a++) issue(1, 6'(a), 16'($urandom), 0);
    reset = 1;
    @(negedge clock);
    reset = 0;
    len_m = 0;
    issue(1, 63, 16'h7E3F, 0);
    issue(0, 0, 0, 1);
    wait_halt(1);
    issue(1, 0, 16'h5555, 1);
    wait_halt(0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
